// File: rtl/overvoltage_pkg.sv
// Shared definitions for the overvoltage filter: FSM state encoding,
// settle/filter counter widths and the default synchronizer depth.
package overvoltage_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        ARMED  = 2'd2
    } ov_state_e;

    localparam int unsigned SETTLE_W        = 8;
    localparam int unsigned FILT_W          = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/ov_sync.sv
// Multi-flop synchronizer for the asynchronous comparator output.
// Ports:
//   clk     - destination clock
//   rst     - asynchronous active-high reset, clears every stage
//   d_async - asynchronous input
//   q_sync  - synchronized output (last stage)
module ov_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q_sync
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/overvoltage_filter.sv
// Overvoltage monitor controller: enables the analog macro, blanks its
// output while it settles, debounces the synchronized comparator output
// and keeps sticky/interrupt/event-count status.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   ena_req         - software enable request
//   settle_cnt      - blanking cycles after enable
//   filt_cnt        - debounce length (level must persist filt_cnt+1 cycles)
//   ovout           - raw asynchronous comparator output
//   clr             - pulse clearing ov_sticky and ov_count
//   irq_en          - interrupt enable
//   ena             - enable to the analog macro
//   ov_flag         - debounced overvoltage level
//   ov_sticky       - latched overvoltage occurrence
//   irq             - ov_sticky gated by irq_en
//   ov_count        - saturating count of ov_flag rising edges
//   state           - current FSM state (debug)
module overvoltage_filter
    import overvoltage_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena_req,
    input  logic [SETTLE_W-1:0] settle_cnt,
    input  logic [FILT_W-1:0]   filt_cnt,
    input  logic                ovout,
    input  logic                clr,
    input  logic                irq_en,
    output logic                ena,
    output logic                ov_flag,
    output logic                ov_sticky,
    output logic                irq,
    output logic [CNT_W-1:0]    ov_count,
    output logic [1:0]          state
);

    ov_state_e           state_q,     state_d;
    logic [SETTLE_W-1:0] settle_q,    settle_d;
    logic [FILT_W-1:0]   dbnc_q,      dbnc_d;
    logic                ov_flag_q,   ov_flag_d;
    logic                ov_sticky_q, ov_sticky_d;
    logic                irq_q,       irq_d;
    logic                ena_q,       ena_d;
    logic [CNT_W-1:0]    ov_count_q,  ov_count_d;
    logic                ov_s;
    logic                rise;

    ov_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (ovout),
        .q_sync  (ov_s)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        dbnc_d    = '0;
        ov_flag_d = 1'b0;

        case (state_q)
            OFF: begin
                if (ena_req) begin
                    settle_d = settle_cnt;
                    state_d  = (settle_cnt == '0) ? ARMED : SETTLE;
                end
            end
            SETTLE: begin
                // Leave on the cycle the counter reaches zero.
                if (settle_q <= SETTLE_W'(1)) begin
                    settle_d = '0;
                    state_d  = ARMED;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            ARMED: begin
                ov_flag_d = ov_flag_q;
                if (ov_s != ov_flag_q) begin
                    // >= so a lowered filt_cnt mid-debounce takes effect at once.
                    if (dbnc_q >= filt_cnt) begin
                        ov_flag_d = ~ov_flag_q;
                    end else begin
                        dbnc_d = dbnc_q + FILT_W'(1);
                    end
                end
            end
            default: state_d = OFF;
        endcase

        // Disable overrides everything except sticky status and count.
        if (!ena_req) begin
            state_d   = OFF;
            settle_d  = '0;
            dbnc_d    = '0;
            ov_flag_d = 1'b0;
        end

        rise = ov_flag_d & ~ov_flag_q;

        // Set wins over clear.
        if (rise) begin
            ov_sticky_d = 1'b1;
        end else if (clr) begin
            ov_sticky_d = 1'b0;
        end else begin
            ov_sticky_d = ov_sticky_q;
        end

        // clr coinciding with a rising edge yields exactly one event.
        if (clr) begin
            ov_count_d = rise ? CNT_W'(1) : '0;
        end else if (rise && (ov_count_q != '1)) begin
            ov_count_d = ov_count_q + CNT_W'(1);
        end else begin
            ov_count_d = ov_count_q;
        end

        ena_d = (state_d != OFF);
        irq_d = ov_sticky_d & irq_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OFF;
            settle_q    <= '0;
            dbnc_q      <= '0;
            ov_flag_q   <= 1'b0;
            ov_sticky_q <= 1'b0;
            irq_q       <= 1'b0;
            ena_q       <= 1'b0;
            ov_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            dbnc_q      <= dbnc_d;
            ov_flag_q   <= ov_flag_d;
            ov_sticky_q <= ov_sticky_d;
            irq_q       <= irq_d;
            ena_q       <= ena_d;
            ov_count_q  <= ov_count_d;
        end
    end

    assign ena       = ena_q;
    assign ov_flag   = ov_flag_q;
    assign ov_sticky = ov_sticky_q;
    assign irq       = irq_q;
    assign ov_count  = ov_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_overvoltage_filter.sv
module tb_overvoltage_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena_req;
    logic [7:0] settle_cnt;
    logic [3:0] filt_cnt;
    logic       ovout;
    logic       clr;
    logic       irq_en;

    logic       ena, ov_flag, ov_sticky, irq;
    logic [7:0] ov_count;
    logic [1:0] state;

    logic       ena2, ov_flag2, ov_sticky2, irq2;
    logic [1:0] ov_count2;
    logic [1:0] state2;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    errors = 0;
    int    checks = 0;

    localparam logic [1:0] S_OFF = 2'd0, S_SETTLE = 2'd1, S_ARMED = 2'd2;

    always #5 clk = ~clk;

    overvoltage_filter #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ena_req(ena_req), .settle_cnt(settle_cnt),
        .filt_cnt(filt_cnt), .ovout(ovout), .clr(clr), .irq_en(irq_en),
        .ena(ena), .ov_flag(ov_flag), .ov_sticky(ov_sticky), .irq(irq),
        .ov_count(ov_count), .state(state)
    );

    overvoltage_filter #(.SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ena_req(ena_req), .settle_cnt(settle_cnt),
        .filt_cnt(filt_cnt), .ovout(ovout), .clr(clr), .irq_en(irq_en),
        .ena(ena2), .ov_flag(ov_flag2), .ov_sticky(ov_sticky2), .irq(irq2),
        .ov_count(ov_count2), .state(state2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic check_outputs(input string ph, input logic [1:0] e_state,
                                 input logic e_ena, input logic e_flag,
                                 input logic e_sticky, input logic e_irq,
                                 input logic [7:0] e_cnt, input logic [1:0] e_cnt2);
        push({ph, ".state"},  32'(e_state));
        push({ph, ".ena"},    32'(e_ena));
        push({ph, ".flag"},   32'(e_flag));
        push({ph, ".sticky"}, 32'(e_sticky));
        push({ph, ".irq"},    32'(e_irq));
        push({ph, ".count"},  32'(e_cnt));
        push({ph, ".count2"}, 32'(e_cnt2));
        push({ph, ".flag2"},  32'(e_flag));
        pop_check(32'(state));
        pop_check(32'(ena));
        pop_check(32'(ov_flag));
        pop_check(32'(ov_sticky));
        pop_check(32'(irq));
        pop_check(32'(ov_count));
        pop_check(32'(ov_count2));
        pop_check(32'(ov_flag2));
    endtask

    initial begin
        rst = 1'b1; ena_req = 1'b0; settle_cnt = '0; filt_cnt = '0;
        ovout = 1'b0; clr = 1'b0; irq_en = 1'b0;

        // Reset state before any clock edge
        #2;
        check_outputs("reset", S_OFF, 0, 0, 0, 0, 8'd0, 2'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        push("idle.state", 32'(S_OFF)); pop_check(32'(state));

        // Enable with settle_cnt=5
        settle_cnt = 8'd5; filt_cnt = 4'd3; irq_en = 1'b1; ena_req = 1'b1;
        push("en.ena", 32'd1); push("en.state1", 32'(S_SETTLE));
        tick();
        pop_check(32'(ena)); pop_check(32'(state));
        for (int i = 2; i <= 5; i++) begin
            push("en.settle", 32'(S_SETTLE));
            tick();
            pop_check(32'(state));
        end
        push("en.armed", 32'(S_ARMED));
        tick();
        pop_check(32'(state));

        // Debounce rise: flag appears on the 6th edge
        ovout = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        push("dbnc.edge5_flag", 32'd0); pop_check(32'(ov_flag));
        tick();
        check_outputs("dbnc_rise", S_ARMED, 1, 1, 1, 1, 8'd1, 2'd1);

        // 3-cycle glitch must not disturb the flag
        ovout = 1'b0;
        tick(); tick(); tick();
        ovout = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push("glitch.flag", 32'd1);
            tick();
            pop_check(32'(ov_flag));
        end

        // Falling level also debounced
        ovout = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        push("fall.edge5_flag", 32'd1); pop_check(32'(ov_flag));
        tick();
        check_outputs("fall", S_ARMED, 1, 0, 1, 1, 8'd1, 2'd1);

        // Plain clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_outputs("clr", S_ARMED, 1, 0, 0, 0, 8'd0, 2'd0);

        // Clear coinciding with rising edge: set wins, count = 1
        ovout = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_outputs("race", S_ARMED, 1, 1, 1, 1, 8'd1, 2'd1);

        // Disable mid-trip
        ena_req = 1'b0;
        tick();
        check_outputs("disable", S_OFF, 0, 0, 1, 1, 8'd1, 2'd1);

        // Re-enable with settle_cnt=0 goes straight to ARMED; filt_cnt=0
        ovout = 1'b0; filt_cnt = 4'd0; settle_cnt = 8'd0;
        tick(); tick(); tick();
        ena_req = 1'b1;
        tick();
        push("direct.state", 32'(S_ARMED)); push("direct.ena", 32'd1);
        pop_check(32'(state)); pop_check(32'(ena));

        // Five clean pulses: 8-bit count reaches 6, 2-bit count sticks at 3
        for (int p = 0; p < 5; p++) begin
            ovout = 1'b1;
            tick(); tick();
            push("sat.pre_flag", 32'd0); pop_check(32'(ov_flag));
            tick();
            push("sat.rise_flag", 32'd1); pop_check(32'(ov_flag));
            tick();
            ovout = 1'b0;
            tick(); tick(); tick(); tick();
        end
        check_outputs("sat", S_ARMED, 1, 0, 1, 1, 8'd6, 2'd3);

        // Reset asserted between edges during SETTLE
        ena_req = 1'b0;
        tick();
        settle_cnt = 8'd10; ena_req = 1'b1;
        tick();
        push("rst_mid.settle", 32'(S_SETTLE)); pop_check(32'(state));
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_outputs("rst_mid", S_OFF, 0, 0, 0, 0, 8'd0, 2'd0);
        #2;
        rst = 1'b0;
        #1;
        push("rst_rel.hold_off", 32'(S_OFF)); pop_check(32'(state));
        tick();
        push("rst_rel.settle", 32'(S_SETTLE)); pop_check(32'(state));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
